// File: rtl/dvi_tx_pkg.sv
// Shared state encoding and colour-bar constants for the DVI transmit timing generator.
package dvi_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_e;

    localparam logic [23:0] RGB_WHITE   = 24'hFF_FF_FF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFF_FF_00;
    localparam logic [23:0] RGB_CYAN    = 24'h00_FF_FF;
    localparam logic [23:0] RGB_GREEN   = 24'h00_FF_00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF_00_FF;
    localparam logic [23:0] RGB_RED     = 24'hFF_00_00;
    localparam logic [23:0] RGB_BLUE    = 24'h00_00_FF;
    localparam logic [23:0] RGB_BLACK   = 24'h00_00_00;

    // Bars run left to right from white down to black.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = RGB_WHITE;
            3'd1:    rgb = RGB_YELLOW;
            3'd2:    rgb = RGB_CYAN;
            3'd3:    rgb = RGB_GREEN;
            3'd4:    rgb = RGB_MAGENTA;
            3'd5:    rgb = RGB_RED;
            3'd6:    rgb = RGB_BLUE;
            3'd7:    rgb = RGB_BLACK;
            default: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/dvi_tx_counter.sv
// Horizontal/vertical raster counters with sync and active-region decode.
module dvi_tx_counter #(
    parameter int H_ACTIVE = 128,
    parameter int H_FRONT  = 4,
    parameter int H_SYNC   = 8,
    parameter int H_TOTAL  = 144,
    parameter int V_ACTIVE = 32,
    parameter int V_FRONT  = 2,
    parameter int V_SYNC   = 2,
    parameter int V_TOTAL  = 40,
    parameter int H_W      = $clog2(H_TOTAL + 1),
    parameter int V_W      = $clog2(V_TOTAL + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output logic           hs,
    output logic           vs,
    output logic           active,
    output logic           frame_last
);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FRONT);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FRONT);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [H_W-1:0] H_ONE    = H_W'(1);
    localparam logic [V_W-1:0] V_ONE    = V_W'(1);

    // Raster advance; parked at the origin whenever the generator is stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + V_ONE;
            end
        end else begin
            h_cnt <= h_cnt + H_ONE;
        end
    end

    // Position decode for the current raster point.
    always_comb begin
        hs         = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs         = (v_cnt >= VS_START) && (v_cnt < VS_END);
        active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

endmodule

// File: rtl/dvi_tx_timing_gen.sv
// DVI transmit timing generator: raster FSM, pixel handshake and registered RGB outputs.
// Define DVI_TX_PATTERN_EN to substitute colour bars instead of black on input underflow.
module dvi_tx_timing_gen
    import dvi_tx_pkg::*;
#(
    parameter int H_ACTIVE = 128,
    parameter int H_FRONT  = 4,
    parameter int H_SYNC   = 8,
    parameter int H_TOTAL  = 144,
    parameter int V_ACTIVE = 32,
    parameter int V_FRONT  = 2,
    parameter int V_SYNC   = 2,
    parameter int V_TOTAL  = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       I_enable,
    input  logic       I_pix_valid,
    input  logic [7:0] I_pix_r,
    input  logic [7:0] I_pix_g,
    input  logic [7:0] I_pix_b,
    output logic       O_pix_ready,
    output logic       O_rgb_hs,
    output logic       O_rgb_vs,
    output logic       O_rgb_de,
    output logic [7:0] O_rgb_r,
    output logic [7:0] O_rgb_g,
    output logic [7:0] O_rgb_b,
    output logic       O_frame_start,
    output logic       O_underflow
);

    localparam int H_W = $clog2(H_TOTAL + 1);
    localparam int V_W = $clog2(V_TOTAL + 1);

    tx_state_e      state_r;
    logic           run_s;
    logic           ready_s;
    logic           first_s;
    logic [H_W-1:0] h_cnt_s;
    logic [V_W-1:0] v_cnt_s;
    logic           hs_s;
    logic           vs_s;
    logic           active_s;
    logic           frame_last_s;
    logic [23:0]    sub_rgb_s;
    logic [23:0]    pix_rgb_s;

    dvi_tx_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_TOTAL  (V_TOTAL),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run_s),
        .h_cnt      (h_cnt_s),
        .v_cnt      (v_cnt_s),
        .hs         (hs_s),
        .vs         (vs_s),
        .active     (active_s),
        .frame_last (frame_last_s)
    );

`ifdef DVI_TX_PATTERN_EN
    localparam int HA_W = $clog2(H_ACTIVE);
    assign sub_rgb_s = bar_colour(h_cnt_s[HA_W-1 -: 3]);
`else
    assign sub_rgb_s = RGB_BLACK;
`endif

    // Handshake and pixel selection; a missing input pixel never stalls the raster.
    always_comb begin
        run_s   = (state_r != ST_IDLE);
        ready_s = run_s && active_s;
        first_s = (h_cnt_s == '0) && (v_cnt_s == '0);
        if (I_pix_valid) begin
            pix_rgb_s = {I_pix_r, I_pix_g, I_pix_b};
        end else begin
            pix_rgb_s = sub_rgb_s;
        end
    end

    assign O_pix_ready = ready_s;

    // Raster state: start on enable, always finish the current frame before idling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (I_enable) state_r <= ST_RUN;
                    else          state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    if (!I_enable) state_r <= ST_DRAIN;
                    else           state_r <= ST_RUN;
                end
                ST_DRAIN: begin
                    if (I_enable)          state_r <= ST_RUN;
                    else if (frame_last_s) state_r <= ST_IDLE;
                    else                   state_r <= ST_DRAIN;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Output stage, one cycle behind the raster position and input sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O_rgb_hs      <= 1'b0;
            O_rgb_vs      <= 1'b0;
            O_rgb_de      <= 1'b0;
            O_rgb_r       <= 8'h00;
            O_rgb_g       <= 8'h00;
            O_rgb_b       <= 8'h00;
            O_frame_start <= 1'b0;
            O_underflow   <= 1'b0;
        end else begin
            O_rgb_hs      <= run_s && hs_s;
            O_rgb_vs      <= run_s && vs_s;
            O_rgb_de      <= ready_s;
            O_frame_start <= ready_s && first_s;
            O_underflow   <= ready_s && !I_pix_valid;
            if (ready_s) begin
                {O_rgb_r, O_rgb_g, O_rgb_b} <= pix_rgb_s;
            end else begin
                {O_rgb_r, O_rgb_g, O_rgb_b} <= 24'h00_00_00;
            end
        end
    end

endmodule

// File: doc/dvi_tx_timing_gen.md
DVI_TX_TIMING_GEN -- requirements
Module: dvi_tx_timing_gen

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning:
  H_ACTIVE 128 active pixels per line; H_FRONT 4 front porch; H_SYNC 8 hsync width; H_TOTAL 144 line length.
  V_ACTIVE 32 active lines; V_FRONT 2 front porch; V_SYNC 2 vsync width; V_TOTAL 40 frame length.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning:
  clk  in  1  pixel clock, the single clock.
  rst_n  in  1  asynchronous active-low reset.
  I_enable  in  1  level; request video output.
  I_pix_valid  in  1  upstream pixel available.
  I_pix_r / I_pix_g / I_pix_b  in  8 each  upstream pixel.
  O_pix_ready  out  1  pixel consumed this cycle when I_pix_valid is also high.
  O_rgb_hs / O_rgb_vs / O_rgb_de  out  1 each  video timing, active-high.
  O_rgb_r / O_rgb_g / O_rgb_b  out  8 each  pixel data, zero when O_rgb_de is low.
  O_frame_start  out  1  one-cycle pulse aligned with output pixel (0,0).
  O_underflow  out  1  one-cycle pulse on an active pixel with no valid input.
REQ-003 The block SHALL use one clock (clk) and SHALL reset asynchronously on rst_n low (active-low).

Function
REQ-010 h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL advance only on h_cnt wrap and wrap from V_TOTAL-1 to 0.
REQ-011 The active region SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-012 hs SHALL be high for H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC; vs SHALL use the same rule on v_cnt.
REQ-013 The FSM SHALL have three states:
  IDLE: counters held at 0, no timing output.
  RUN: counters free-running.
  DRAIN: counters running until the end of the current frame.
REQ-014 FSM transitions SHALL be:
  IDLE->RUN when I_enable=1.
  RUN->DRAIN when I_enable=0.
  DRAIN->RUN when I_enable=1.
  DRAIN->IDLE when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
  A frame SHALL never be truncated.
REQ-015 O_pix_ready SHALL be combinational: high if and only if the state is RUN or DRAIN and the counters are in the active region.
REQ-016 A pixel SHALL be consumed when O_pix_ready and I_pix_valid are both high; the upstream side SHALL hold data until consumed.
REQ-017 All O_rgb_* outputs, O_frame_start and O_underflow SHALL be registered, with a latency of 1 cycle from the counter state and the input sample.
REQ-018 When O_pix_ready=1 and I_pix_valid=0: O_rgb_de SHALL still be 1, the substitute pixel SHALL be output (REQ-040), O_underflow SHALL pulse, and timing SHALL never stall.
REQ-019 Outside the active region, O_rgb_r/g/b SHALL be 0.
REQ-020 O_frame_start SHALL pulse for exactly one cycle per frame, coincident with the first O_rgb_de of the frame.
REQ-021 In IDLE, O_rgb_hs, O_rgb_vs, O_rgb_de and O_pix_ready SHALL be 0.

Reset
REQ-030 On rst_n low, the state SHALL be IDLE, h_cnt=v_cnt=0, and all outputs SHALL be 0, immediately and asynchronously.
REQ-031 Reset asserted mid-frame SHALL abort the frame; after release, output SHALL restart at (0,0) only after I_enable is sampled high.

Configuration
REQ-040 With DVI_TX_PATTERN_EN defined, the underflow substitute pixel SHALL be 8 vertical colour bars of width H_ACTIVE/8, selected by h_cnt[msb-2:msb]:
  white, yellow, cyan, green, magenta, red, blue, black; components are 0xFF or 0x00.
  Without DVI_TX_PATTERN_EN, the substitute SHALL be black (0,0,0), and no bar logic SHALL exist.

Structure
REQ-050 The state enum and the colour-bar lookup constants SHALL live in the shared package dvi_tx_pkg.
REQ-051 The h/v counter pair with its sync decode SHALL be the sub-module dvi_tx_counter; FSM, handshake and output registers SHALL stay in the top module.

Verification
REQ-060 The bench SHALL cover these directed scenarios:
  (1) Default parameters, I_enable=1, I_pix_valid=1 constant:
      - exactly 4096 consumed pixels per frame.
      - frame period 5760 clocks.
      - hs high for h_cnt 132..139, vs high for lines 34..35.
  (2) Input data equal to a pixel index:
      - O_rgb_r/g/b equal the consumed values one cycle after consumption, in order.
      - no O_underflow pulse.
  (3) I_pix_valid=0 for pixels 10..12 of line 0:
      - O_underflow pulses 3 times.
      - de is unbroken.
      - substitute is bar 0 (FF,FF,FF) with the macro defined; (00,00,00) without it.
  (4) I_enable dropped at line 5:
      - the frame completes through v_cnt=39, then IDLE with all outputs 0.
      - I_enable re-raised: O_frame_start pulses 1 cycle after the first active pixel.
  (5) rst_n pulsed low at line 20, pixel 50:
      - outputs go to 0 the same cycle.
      - after release with I_enable=1, the next O_frame_start precedes any hs.
  (6) Non-default parameters H_ACTIVE=8, H_TOTAL=12, V_ACTIVE=2, V_TOTAL=4: 16 pixels consumed per 48-cycle frame.
